// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands arrive over a valid/ready handshake and the result leaves with its register tag over a second one.
module div_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BITS_PER_CY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [5:0]      rd_addr_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] result,
    output logic [5:0]      rd_addr
);

    localparam int unsigned STEPS = XLEN / BITS_PER_CY;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam int unsigned TAG_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [TAG_W-1:0]   r_tag;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_rd_addr;
    logic               r_valid_out;

    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [XLEN-1:0]    w_special_res;
    logic [XLEN-1:0]    w_quo_nxt;
    logic [XLEN-1:0]    w_rem_nxt;
    logic [XLEN-1:0]    w_quo_fin;
    logic [XLEN-1:0]    w_rem_fin;
    logic [XLEN-1:0]    w_calc_res;

    assign ready_out = (r_state == S_IDLE) || ((r_state == S_DONE) && ready_in);
    assign w_accept  = valid_in && ready_out && !flush;

    // Operand decode: signed ops divide magnitudes and fix signs at the end
    assign w_signed   = ~div_op[0];
    assign w_a_neg    = w_signed & rs1_data[XLEN-1];
    assign w_b_neg    = w_signed & rs2_data[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
    assign w_b_mag    = w_b_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
    assign w_div_zero = (rs2_data == '0);
    assign w_ovf      = w_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = div_op[1] ? rs1_data : '1;
        end else if (w_ovf) begin
            w_special_res = div_op[1] ? '0 : rs1_data;
        end
    end

    // BITS_PER_CY restoring steps; the trial subtract is one bit wider than the operands
    always_comb begin : p_step
        logic [XLEN:0]   v_wide;
        logic [XLEN-1:0] v_rem;
        logic [XLEN-1:0] v_quo;
        v_wide = '0;
        v_rem  = r_rem;
        v_quo  = r_quo;
        for (int i = 0; i < int'(BITS_PER_CY); i++) begin
            v_wide = {v_rem, v_quo[XLEN-1]};
            v_quo  = {v_quo[XLEN-2:0], 1'b0};
            if (v_wide >= {1'b0, r_div}) begin
                v_wide   = v_wide - {1'b0, r_div};
                v_quo[0] = 1'b1;
            end
            v_rem = v_wide[XLEN-1:0];
        end
        w_rem_nxt = v_rem;
        w_quo_nxt = v_quo;
    end

    assign w_quo_fin  = r_neg_q ? (~w_quo_nxt + XLEN'(1)) : w_quo_nxt;
    assign w_rem_fin  = r_neg_r ? (~w_rem_nxt + XLEN'(1)) : w_rem_nxt;
    assign w_calc_res = r_is_rem ? w_rem_fin : w_quo_fin;

    // Control FSM; an accept can only occur in IDLE or on the DONE handshake cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_tag       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_rd_addr   <= '0;
            r_valid_out <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_valid_out <= 1'b0;
        end else if (w_accept) begin
            r_is_rem <= div_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_tag    <= rd_addr_in;
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_div    <= w_b_mag;
            r_cnt    <= CNT_W'(STEPS);
            if (w_special) begin
                r_result    <= w_special_res;
                r_rd_addr   <= rd_addr_in;
                r_valid_out <= 1'b1;
                r_state     <= S_DONE;
            end else begin
                r_valid_out <= 1'b0;
                r_state     <= S_CALC;
            end
        end else begin
            case (r_state)
                S_CALC: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result    <= w_calc_res;
                        r_rd_addr   <= r_tag;
                        r_valid_out <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_in) begin
                        r_valid_out <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign valid_out = r_valid_out;
    assign result    = r_result;
    assign rd_addr   = r_rd_addr;

endmodule
